// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receiver with first-word-fall-through byte FIFO.
//
// Deserializes 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from the
// asynchronous rx pin, buffers good bytes in a small FIFO and raises a level
// interrupt while data is waiting or an error flag is set.
//
// Optional feature macro: UART_RX_PARITY_EN (adds even-parity bit and PAR state)
//
// Ports:
//   wb_clk_i    in   sole clock
//   wb_rst_i    in   asynchronous active-high reset
//   rx          in   serial input, asynchronous, idles high
//   clk_div     in   clock cycles per bit (>= 4), latched at start of frame
//   rd_en       in   pop FIFO head (ignored when empty)
//   rd_data     out  FIFO head byte
//   rd_valid    out  FIFO not empty
//   level       out  FIFO occupancy
//   err_clr     in   clear sticky error flags (a simultaneous set wins)
//   frame_err   out  sticky: stop bit sampled low
//   overrun     out  sticky: byte dropped on a full FIFO
//   parity_err  out  sticky: parity mismatch (0 without the parity macro)
//   irq         out  registered OR of rd_valid and the error flags
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | waiting for a falling edge on rx_s
// START | counting to mid start bit, confirm it is still low
// DATA  | sampling 8 data bits, LSB first
// PAR   | sampling the even-parity bit (parity build only)
// STOP  | sampling the stop bit, then push or flag an error

module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx,
  input  logic [CNT_W-1:0]              clk_div,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic                          err_clr,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  output logic                          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic             rx_m, rx_s, rx_d;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_q, div_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shreg, sh_n;
  logic             push_n, push_q;
  logic             ferr_n, ferr_q;
  logic             fall, tick;

`ifdef UART_RX_PARITY_EN
  logic             par_bad, pbad_n;
  logic             perr_n, perr_q;
`endif

  // Synchronizer plus one extra flop for falling-edge detection.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign tick = (cnt == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_q   <= div_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      push_q  <= push_n;
      ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= pbad_n;
      perr_q  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_q;
    bit_n   = bit_idx;
    sh_n    = shreg;
    push_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n  = par_bad;
    perr_n  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n = S_START;
          div_n   = clk_div;
          cnt_n   = clk_div >> 1;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            cnt_n   = div_q - CNT_ONE;
            bit_n   = 3'd0;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_n  = {rx_s, shreg[7:1]};
          cnt_n = div_q - CNT_ONE;
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PAR;
`else
            state_n = S_STOP;
`endif
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          pbad_n  = rx_s ^ (^shreg);
          cnt_n   = div_q - CNT_ONE;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          state_n = S_IDLE;
          // A low stop bit takes priority over a parity mismatch.
          if (!rx_s) begin
            ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_n = 1'b1;
`endif
          end else begin
            push_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, do_pop, do_push, ovr_set;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still fits.
  assign ovr_set = push_q & full & ~do_pop;
  assign do_push = push_q & ~ovr_set;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign rd_valid = ~empty;
  assign level    = wr_ptr - rd_ptr;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      frame_err <= ferr_q  | (frame_err & ~err_clr);
      overrun   <= ovr_set | (overrun & ~err_clr);
      irq       <= rd_valid | frame_err | overrun | parity_err;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) parity_err <= 1'b0;
    else          parity_err <= perr_q | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] clk_div;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  level;
  logic        err_clr;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic rv_hist  [0:63];
  logic irq_hist [0:63];

  uart_rx_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx         (rx),
    .clk_div    (clk_div),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .err_clr    (err_clr),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold one bit for clk_div cycles; the history of rd_valid/irq is recorded
  // after each edge, and err_clr/rd_en are pulsed so that the edge numbered
  // idx+1 within the bit sees them high.
  task automatic send_bit(input logic b, input int clr_idx, input int rd_idx);
    rx = b;
    for (int i = 0; i < int'(clk_div); i++) begin
      @(posedge clk);
      #1;
      rv_hist[i]  = rd_valid;
      irq_hist[i] = irq;
      err_clr     = (i == clr_idx);
      rd_en       = (i == rd_idx);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                            input int clr_idx, input int rd_idx);
    send_bit(1'b0, -1, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], -1, -1);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip, -1, -1);
`endif
    send_bit(stop_v, clr_idx, rd_idx);
    rx = 1'b1;
  endtask

  task automatic pop;
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    clk_div = 16'd16;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_level", level, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_irq", irq, 0);
    rst = 1'b0;
    idle(4);

    // Basic frame with push/irq latency measured during the stop bit:
    // stop sample at stop-bit edge 12, push visible after edge 13, irq after 14.
    send_frame(8'h3D, 1'b1, 1'b0, -1, -1);
    chk("t1_rv_before_push", rv_hist[11], 0);
    chk("t1_rv_after_push", rv_hist[12], 1);
    chk("t1_irq_lag", irq_hist[12], 0);
    chk("t1_irq_set", irq_hist[13], 1);
    chk("t1_rd_data", rd_data, 8'h3D);
    chk("t1_level", level, 1);
    pop();
    chk("t1_rv_after_pop", rd_valid, 0);
    chk("t1_irq_still_high", irq, 1);
    idle(1);
    chk("t1_irq_clear", irq, 0);

    // Glitch shorter than half a bit must not produce anything.
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    chk("glitch_level", level, 0);
    chk("glitch_rd_valid", rd_valid, 0);
    chk("glitch_frame_err", frame_err, 0);
    send_frame(8'h42, 1'b1, 1'b0, -1, -1);
    idle(2);
    chk("after_glitch_data", rd_data, 8'h42);
    chk("after_glitch_level", level, 1);
    pop();

    // Different divider.
    clk_div = 16'd10;
    send_frame(8'hC6, 1'b1, 1'b0, -1, -1);
    idle(2);
    chk("div10_data", rd_data, 8'hC6);
    chk("div10_level", level, 1);
    pop();
    clk_div = 16'd16;
    idle(4);

    // Framing error, clear, and clear colliding with a new set.
    send_frame(8'h0F, 1'b0, 1'b0, -1, -1);
    idle(20);
    chk("ferr_set", frame_err, 1);
    chk("ferr_level", level, 0);
    chk("ferr_irq", irq, 1);
    clear_errs();
    chk("ferr_cleared", frame_err, 0);
    idle(4);
    send_frame(8'h0F, 1'b0, 1'b0, 11, -1);
    idle(20);
    chk("ferr_set_wins", frame_err, 1);
    clear_errs();
    chk("ferr_cleared2", frame_err, 0);
    idle(4);

    // Fill the FIFO back-to-back, then overflow.
    for (int b = 0; b < 8; b++) send_frame(8'(b), 1'b1, 1'b0, -1, -1);
    idle(2);
    chk("fill_level", level, 8);
    chk("fill_overrun", overrun, 0);
    send_frame(8'h08, 1'b1, 1'b0, -1, -1);
    idle(2);
    chk("ovr_level", level, 8);
    chk("ovr_flag", overrun, 1);
    chk("ovr_head", rd_data, 8'h00);
    clear_errs();
    chk("ovr_cleared", overrun, 0);
    // Push and pop on the same edge while full.
    send_frame(8'h08, 1'b1, 1'b0, -1, 11);
    idle(2);
    chk("fullrw_level", level, 8);
    chk("fullrw_overrun", overrun, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_%0d", k), rd_data, 32'(k));
      pop();
    end
    chk("drain_level", level, 0);
    chk("drain_rd_valid", rd_valid, 0);

    // Reset in the middle of a frame.
    send_bit(1'b0, -1, -1);
    send_bit(1'b1, -1, -1);
    send_bit(1'b0, -1, -1);
    send_bit(1'b1, -1, -1);
    rst = 1'b1;
    rx  = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("midrst_level", level, 0);
    idle(10);
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
    idle(20);
    chk("midrst_data", rd_data, 8'h5A);
    chk("midrst_level2", level, 1);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_ovr", overrun, 0);
    chk("midrst_perr", parity_err, 0);
    pop();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, -1, -1);
    idle(4);
    chk("par_bad_flag", parity_err, 1);
    chk("par_bad_level", level, 0);
    clear_errs();
    chk("par_cleared", parity_err, 0);
    send_frame(8'h03, 1'b1, 1'b0, -1, -1);
    idle(4);
    chk("par_ok_flag", parity_err, 0);
    chk("par_ok_level", level, 1);
    chk("par_ok_data", rd_data, 8'h03);
    pop();
`endif

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

User-project UART receiver for the Caravel mprj side. It deserializes 8N1 frames arriving on the `mprj_io[5]` receive pad, which is driven by the bench UART's transmitter. Received bytes are buffered in a small first-word-fall-through FIFO. Firmware drains the FIFO through a read strobe and is told about data or errors by a level interrupt.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `CNT_W`, default 16: width of the baud divider.

Ports:
- `wb_clk_i`, in, 1: sole clock.
- `wb_rst_i`, in, 1: reset, asynchronous, active-high.
- `rx`, in, 1: serial input, asynchronous to the clock, idles high.
- `clk_div`, in, `CNT_W`: clock cycles per bit; legal range ≥ 4.
- `rd_en`, in, 1: pop the FIFO head; ignored when empty.
- `rd_data`, out, 8: FIFO head, valid while `rd_valid` is high.
- `rd_valid`, out, 1: FIFO not empty.
- `level`, out, log2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `err_clr`, in, 1: clears the sticky error flags.
- `frame_err`, out, 1: sticky; a stop bit was sampled low.
- `overrun`, out, 1: sticky; a byte was dropped because the FIFO was full.
- `parity_err`, out, 1: sticky; parity mismatch (see Configuration).
- `irq`, out, 1: registered `rd_valid | frame_err | overrun | parity_err`.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All sampling uses `rx_s`.
- The FSM has five states: IDLE, START, DATA, PAR, STOP. PAR exists only when the parity macro is defined.
- IDLE → START: on a falling edge of `rx_s` (previous sample 1, current sample 0).
  - On entry, `clk_div` is latched into `div_q` for the whole frame.
  - The baud counter is loaded with `div_q>>1`.
- START: when the counter reaches 0, `rx_s` is resampled (mid-bit).
  - If it reads 1: false start, go to IDLE with nothing recorded.
  - If it reads 0: reload the counter with `div_q-1` and go to DATA.
- DATA: at each counter expiry, sample one bit into a shift register, LSB first, then reload the counter.
  - After 8 bits, go to PAR if configured, otherwise to STOP.
- PAR: sample one bit; compare it with even parity (XOR) of the 8 data bits.
- STOP: sample one bit.
  - 1 and parity OK: push the byte.
  - 0: set `frame_err` and discard the byte.
  - Parity bad: set `parity_err` and discard the byte.
  - In all cases return to IDLE.
  - After a break (line held low), a new start bit needs `rx_s` to go high and then fall again.
- FIFO: circular buffer with read/write pointers one bit wider than the address.
  - Full when the MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
- Push while full: the byte is dropped, `overrun` is set, and the FIFO is unchanged.
- Push and `rd_en` in the same cycle while full: both happen, `overrun` is not set, `level` is unchanged.
- Push and `rd_en` in the same cycle while empty: the pop is ignored, the push happens, and `level` becomes 1.
- Sticky flags: when a set and `err_clr` happen in the same cycle, the set wins.
- Pointers wrap modulo 2·`FIFO_DEPTH`.

## Timing
- Reset values:
  - FSM in IDLE, both synchronizer flops at 1, pointers at 0.
  - `rd_valid`=0, `level`=0, `rd_data`=0.
  - All error flags = 0, `irq`=0.
- Reset mid-frame aborts the frame immediately and discards the partial byte.
- From the `rx` pin falling to START entry: 3 cycles (2 synchronizer cycles + edge register).
- Start confirmation: `div_q>>1` cycles after START entry.
- Each data/parity/stop sample: `div_q` cycles after the previous sample.
- A push updates `rd_valid`, `level` and `rd_data` 1 cycle after the stop sample. `irq` follows 1 cycle later.
- `rd_data` is combinational from the head entry. A pop advances the head at the `rd_en` clock edge, so the next byte is visible the following cycle.
- Throughput: back-to-back frames with one stop bit and no idle gap are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1, using the PAR state.
  - A mismatch sets `parity_err` and drops the byte.
- `UART_RX_PARITY_EN` undefined:
  - The frame is 8N1 and no PAR state exists.
  - `parity_err` is tied to 0.

## Test plan
- Reset, `clk_div`=16, send 0x3D 8N1 → `rd_valid` rises 1 cycle after the stop sample, `rd_data`=0x3D, `level`=1, `irq`=1 the next cycle; `rd_en` pulse → `rd_valid`=0, then `irq`=0.
- Glitch: `rx` low for 5 cycles with `clk_div`=16 → no push, no error, FSM back in IDLE.
- Stop bit forced low on byte 0x0F → `frame_err`=1, `level`=0; `err_clr` pulse → `frame_err`=0; `err_clr` in the same cycle as a new frame error → flag stays 1.
- Send 9 bytes 0x00..0x08 with `FIFO_DEPTH`=8 and no reads → `level`=8, `overrun`=1, entries 0x00..0x07; 9th byte arriving on a cycle with `rd_en`=1 → no overrun, `level` stays 8, last entry 0x08.
- Assert `wb_rst_i` mid-DATA of byte 0xA5, then send 0x5A → only 0x5A appears, all flags 0.
- With `UART_RX_PARITY_EN`, send 0x03 with parity bit 1 → `parity_err`=1, no push; send 0x03 with parity bit 0 → push 0x03.
